// File: rtl/axi_cnt_master.sv
// Free-running counter plus a single-outstanding AXI master that writes a
// snapshot of the count to one slave register, reads it back and compares.
module axi_cnt_master #(
    parameter logic [3:0]  AXI_ID   = 4'h1,
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] ADDR_MAX = 32'd7
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] cnt_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt_q, addr_q, data_q;
    logic        aw_done, w_done;
    logic        err_q, err_nxt;
    logic [7:0]  wait_cnt;
    logic        tmo, aw_hs, w_hs;

    // On the timeout cycle every valid/ready is already low, so a late
    // handshake can never race the abort.
    assign tmo       = (wait_cnt == TIMEOUT);
    assign awvalid_o = (state == WRITE)  && !aw_done && !tmo;
    assign wvalid_o  = (state == WRITE)  && !w_done  && !tmo;
    assign bready_o  = (state == WAIT_B) && !tmo;
    assign arvalid_o = (state == READ)   && !tmo;
    assign rready_o  = (state == WAIT_R) && !tmo;
    assign aw_hs     = awvalid_o && awready_i;
    assign w_hs      = wvalid_o  && wready_i;

    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);
    assign err_o    = err_q;
    assign cnt_o    = cnt_q;
    assign awid_o   = AXI_ID;
    assign wid_o    = AXI_ID;
    assign arid_o   = AXI_ID;
    assign awaddr_o = addr_q;
    assign araddr_o = addr_q;
    assign wdata_o  = data_q;
    assign wstrb_o  = 4'hF;
    assign wlast_o  = 1'b1;

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: if (start_i) begin
                err_nxt = 1'b0;
                if (addr_i > ADDR_MAX) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: if (tmo) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
            end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                state_nxt = WAIT_B;
            end
            WAIT_B: if (tmo) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
            end else if (bvalid_i) begin
                if (bresp_i != 2'b00) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = READ;
                end
            end
            READ: if (tmo) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
            end else if (arready_i) begin
                state_nxt = WAIT_R;
            end
            WAIT_R: if (tmo) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
            end else if (rvalid_i) begin
                state_nxt = DONE;
                err_nxt   = (rdata_i != data_q);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (en_i)
                cnt_q <= cnt_q + 32'd1;
            // Snapshot is the pre-increment value seen on the start edge.
            if (state == IDLE && start_i) begin
                addr_q <= addr_i;
                data_q <= cnt_q;
            end
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state_nxt != state || state == IDLE || state == DONE)
                wait_cnt <= '0;
            else if (!tmo)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_cnt_master.sv
// Scoreboarded bench for axi_cnt_master with a small register-slave model
// whose stalls, response code and read corruption are set per test.
module tb_axi_cnt_master;

    logic        clk = 1'b0;
    logic        areset, en_i, start_i;
    logic [31:0] addr_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] cnt_o;
    logic [3:0]  awid_o, wid_o, arid_o, wstrb_o;
    logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

    axi_cnt_master dut (
        .clk(clk), .areset(areset), .en_i(en_i), .start_i(start_i), .addr_i(addr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cnt_o(cnt_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference counter
    logic [31:0] m_cnt;
    always @(posedge clk) begin
        if (areset)    m_cnt <= '0;
        else if (en_i) m_cnt <= m_cnt + 32'd1;
    end

    // Slave model and its knobs
    int          aw_stall = 0, w_stall = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        b_hold = 1'b0, ar_stuck = 1'b0;
    logic [31:0] r_xor = '0;
    logic [31:0] mem [8];
    int          aw_wait, w_wait, n_wr, n_ar, aw_rise, w_rise, ar_hi, cyc, t_aw, t_w;
    logic        aw_got, w_got, aw_prev, w_prev;
    logic [31:0] aw_addr_l, w_data_l;

    assign awready_i = !aw_got && (aw_wait >= aw_stall);
    assign wready_i  = !w_got  && (w_wait  >= w_stall);
    assign arready_i = !ar_stuck;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid_i <= 1'b0; bresp_i <= 2'b00; rvalid_i <= 1'b0; rdata_i <= '0;
            aw_prev <= 1'b0; w_prev <= 1'b0;
        end else begin
            if (awvalid_o && awready_i) begin
                aw_got <= 1'b1; aw_addr_l <= awaddr_o; aw_wait <= 0; t_aw <= cyc;
            end else if (awvalid_o) aw_wait <= aw_wait + 1;
            if (wvalid_o && wready_i) begin
                w_got <= 1'b1; w_data_l <= wdata_o; w_wait <= 0; t_w <= cyc;
            end else if (wvalid_o) w_wait <= w_wait + 1;
            if (aw_got && w_got && !bvalid_i && !b_hold) begin
                bvalid_i <= 1'b1; bresp_i <= bresp_cfg; n_wr <= n_wr + 1;
                if (bresp_cfg == 2'b00) mem[aw_addr_l[2:0]] <= w_data_l;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid_i && bready_o) bvalid_i <= 1'b0;
            if (arvalid_o && arready_i) begin
                n_ar <= n_ar + 1; rvalid_i <= 1'b1; rdata_i <= mem[araddr_o[2:0]] ^ r_xor;
            end
            if (rvalid_i && rready_o) rvalid_i <= 1'b0;
            aw_prev <= awvalid_o;
            w_prev  <= wvalid_o;
            if (awvalid_o && !aw_prev) aw_rise <= aw_rise + 1;
            if (wvalid_o && !w_prev)   w_rise  <= w_rise + 1;
            if (arvalid_o)             ar_hi   <= ar_hi + 1;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [2:0]  addr;
    } sb_t;
    sb_t sb [$];
    sb_t mon_e;

    always @(negedge clk) begin
        if (!areset && done_o) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: done_o with no expected entry");
            end else begin
                mon_e = sb.pop_front();
                chk("sb_err", {31'd0, err_o}, {31'd0, mon_e.err});
                if (!mon_e.err) begin
                    chk("sb_mem",   mem[mon_e.addr], mon_e.data);
                    chk("sb_wdata", w_data_l,        mon_e.data);
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_seq(input logic [31:0] a, input logic e, input bit push, input int bound);
        start_i = 1'b1;
        addr_i  = a;
        if (push) sb.push_back('{err: e, data: m_cnt, addr: a[2:0]});
        @(negedge clk);
        start_i = 1'b0;
        if (bound > 0) wait_idle(bound);
    endtask

    initial begin
        int d0, d1, d2;
        cyc = 0; n_wr = 0; n_ar = 0; aw_rise = 0; w_rise = 0; ar_hi = 0; t_aw = 0; t_w = 0;
        areset = 1'b1; en_i = 1'b0; start_i = 1'b0; addr_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {24'd0, busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 32'd0);
        chk("rst_cnt", cnt_o, 32'd0);
        chk("const_ids", {19'd0, awid_o, wid_o, arid_o, wlast_o}, {19'd0, 4'h1, 4'h1, 4'h1, 1'b1});
        chk("wstrb", {28'd0, wstrb_o}, 32'hF);
        areset = 1'b0;
        en_i   = 1'b1;
        repeat (10) @(negedge clk);
        chk("cnt_10", cnt_o, 32'd10);

        // Zero-wait write/read-back of word 3, snapshot 10
        run_seq(32'd3, 1'b0, 1'b1, 50);
        chk("wdata_snap", wdata_o, 32'd10);
        chk("mem3", mem[3], 32'd10);

        // AW stalled 4 cycles, W 1 cycle
        aw_stall = 4; w_stall = 1;
        d0 = n_wr; d1 = aw_rise; d2 = w_rise;
        run_seq(32'd1, 1'b0, 1'b1, 50);
        chk("w_before_aw", {31'd0, (t_w < t_aw)}, 32'd1);
        chk("one_write", n_wr - d0, 32'd1);
        chk("aw_pulses", aw_rise - d1, 32'd1);
        chk("w_pulses", w_rise - d2, 32'd1);
        aw_stall = 0; w_stall = 0;

        // Error response: no read issued
        bresp_cfg = 2'b10;
        d0 = n_ar;
        run_seq(32'd2, 1'b1, 1'b1, 50);
        chk("no_ar_on_bresp", n_ar - d0, 32'd0);
        bresp_cfg = 2'b00;

        // Corrupted read-back
        r_xor = 32'd1;
        run_seq(32'd4, 1'b1, 1'b1, 50);
        r_xor = 32'd0;

        // Read address never accepted
        ar_stuck = 1'b1;
        ar_hi = 0;
        run_seq(32'd6, 1'b1, 1'b1, 600);
        chk("ar_timeout_len", ar_hi, 32'd255);
        chk("arvalid_low", {31'd0, arvalid_o}, 32'd0);
        ar_stuck = 1'b0;

        // Out-of-range address: no bus traffic
        d1 = aw_rise;
        run_seq(32'd8, 1'b1, 1'b1, 10);
        chk("bad_addr_no_aw", aw_rise - d1, 32'd0);

        // Counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        chk("cnt_max", cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("cnt_wrap", cnt_o, 32'd0);

        // Reset while waiting for B, then a clean sequence
        b_hold = 1'b1;
        run_seq(32'd2, 1'b0, 1'b0, 0);
        for (int i = 0; i < 50 && !bready_o; i++) @(negedge clk);
        chk("reach_wait_b", {31'd0, bready_o}, 32'd1);
        areset = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", {24'd0, busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 32'd0);
        chk("abort_cnt", cnt_o, 32'd0);
        chk("abort_latch", awaddr_o | wdata_o, 32'd0);
        areset = 1'b0;
        b_hold = 1'b0;
        run_seq(32'd5, 1'b0, 1'b1, 50);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
